// File: rtl/clock_enable_generator.sv
`default_nettype none
// ============================================================================
// Module   : clock_enable_generator
// Purpose  : Synchronous clock-enable source. One free-running counter gives
//            STAGES power-of-two divided clocks, each with a registered
//            rising-edge strobe, plus a runtime-programmable divide-by-N
//            tick whose divisor is swapped only at a period boundary.
// Options  : CLKGEN_SYNC_EN adds a sync_i input that realigns all counters.
// Revision : 1.0 - initial release
// ============================================================================
module clock_enable_generator #(
  parameter int STAGES    = 3,
  parameter int DIV_W     = 8,
  parameter int DIV_RESET = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
`ifdef CLKGEN_SYNC_EN
  input  logic              sync_i,
`endif
  input  logic              enable_i,
  input  logic              div_load_i,
  input  logic [DIV_W-1:0]  div_value_i,
  output logic              div_ack_o,
  output logic              div_pending_o,
  output logic [STAGES-1:0] count_o,
  output logic [STAGES-1:0] clock_div_o,
  output logic [STAGES-1:0] tick_div_o,
  output logic              prog_tick_o
);

  localparam logic [DIV_W-1:0] c_div_reset = DIV_W'(DIV_RESET);
  localparam logic [DIV_W-1:0] c_div_one   = DIV_W'(1);

  // Architectural state
  logic [STAGES-1:0] count_q,    count_d;
  logic [STAGES-1:0] tick_div_q, tick_div_d;
  logic [DIV_W-1:0]  prog_cnt_q, prog_cnt_d;
  logic [DIV_W-1:0]  div_q,      div_d;
  logic [DIV_W-1:0]  pend_val_q, pend_val_d;
  logic              pending_q,  pending_d;
  logic              prog_tick_q, prog_tick_d;
  logic              ack_q,      ack_d;

  logic [STAGES-1:0] w_count_inc;
  logic [STAGES-1:0] w_tick_rise;
  logic              w_div_zero;
  logic              w_tc;
  logic              w_sync;

`ifdef CLKGEN_SYNC_EN
  assign w_sync = sync_i;
`else
  assign w_sync = 1'b0;
`endif

  assign w_count_inc = count_q + STAGES'(1);
  assign w_div_zero  = (div_q == '0);
  // Terminal count only exists for a non-zero divisor
  assign w_tc        = !w_div_zero && (prog_cnt_q == (div_q - c_div_one));

  // A divided clock bit rises exactly where the increment sets a bit that was clear
  for (genvar k = 0; k < STAGES; k++) begin : g_tick_rise
    assign w_tick_rise[k] = w_count_inc[k] & ~count_q[k];
  end

  // Next-state logic for the counters, strobes and divisor handshake
  always_comb begin
    count_d     = count_q;
    tick_div_d  = '0;
    prog_cnt_d  = prog_cnt_q;
    div_d       = div_q;
    pend_val_d  = pend_val_q;
    pending_d   = pending_q;
    prog_tick_d = 1'b0;
    ack_d       = 1'b0;

    // Loads are always captured; a later capture overwrites an earlier one
    if (div_load_i) begin
      pend_val_d = div_value_i;
      pending_d  = 1'b1;
    end

    if (w_sync) begin
      // Realignment wins over everything; any load waits for a later boundary
      count_d    = '0;
      prog_cnt_d = '0;
    end else if (enable_i) begin
      count_d    = w_count_inc;
      tick_div_d = w_tick_rise;
      if (w_div_zero) begin
        // Divider idle: no period to finish, so a captured load goes live now
        prog_cnt_d = '0;
        if (pending_q) begin
          div_d     = pend_val_q;
          ack_d     = 1'b1;
          pending_d = div_load_i;
        end
      end else if (w_tc) begin
        prog_cnt_d  = '0;
        prog_tick_d = 1'b1;
        if (div_load_i) begin
          // Load arriving on the boundary itself bypasses the pending stage
          div_d     = div_value_i;
          ack_d     = 1'b1;
          pending_d = 1'b0;
        end else if (pending_q) begin
          div_d     = pend_val_q;
          ack_d     = 1'b1;
          pending_d = 1'b0;
        end
      end else begin
        prog_cnt_d = prog_cnt_q + c_div_one;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q     <= '0;
      tick_div_q  <= '0;
      prog_cnt_q  <= '0;
      div_q       <= c_div_reset;
      pend_val_q  <= '0;
      pending_q   <= 1'b0;
      prog_tick_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      tick_div_q  <= tick_div_d;
      prog_cnt_q  <= prog_cnt_d;
      div_q       <= div_d;
      pend_val_q  <= pend_val_d;
      pending_q   <= pending_d;
      prog_tick_q <= prog_tick_d;
      ack_q       <= ack_d;
    end
  end

  // All outputs come straight from flops
  assign count_o       = count_q;
  assign clock_div_o   = count_q;
  assign tick_div_o    = tick_div_q;
  assign prog_tick_o   = prog_tick_q;
  assign div_ack_o     = ack_q;
  assign div_pending_o = pending_q;

endmodule
`default_nettype wire
